// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared widths, limits and state encoding for the microwave timer entry
package microwave_pkg;

    localparam int DW = 4;
    localparam logic [DW-1:0] BCD_MAX      = DW'(9);
    localparam logic [DW-1:0] SEC_TENS_MAX = DW'(5);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/time_entry_loader_if.sv
// rtl/time_entry_loader_if.sv - keypad inputs and countdown-chain outputs of the time entry loader
interface time_entry_loader_if;
    import microwave_pkg::*;

    logic [DW-1:0] key;
    logic          key_valid;
    logic          startn;
    logic          clearn_key;
    logic          timer_zero;
    logic          loadn;
    logic [DW-1:0] sec_ones;
    logic [DW-1:0] sec_tens;
    logic [DW-1:0] min_ones;
    logic [DW-1:0] min_tens;
    logic          en;
    logic          busy;
    logic          err;

    modport master (
        output key, key_valid, startn, clearn_key, timer_zero,
        input  loadn, sec_ones, sec_tens, min_ones, min_tens, en, busy, err
    );

    modport slave (
        input  key, key_valid, startn, clearn_key, timer_zero,
        output loadn, sec_ones, sec_tens, min_ones, min_tens, en, busy, err
    );

endinterface

// File: rtl/bcd_shift_reg.sv
// rtl/bcd_shift_reg.sv - four-digit BCD entry buffer shifting new digits in at seconds-ones
module bcd_shift_reg
    import microwave_pkg::*;
(
    input  logic          clk,
    input  logic          clrn,
    input  logic          shift,
    input  logic          clear,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] sec_ones,
    output logic [DW-1:0] sec_tens,
    output logic [DW-1:0] min_ones,
    output logic [DW-1:0] min_tens
);

    // Clear wins over shift; a shift discards the old minutes-tens digit.
    always_ff @(posedge clk) begin
        if (!clrn || clear) begin
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            min_tens <= '0;
        end else if (shift) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= din;
        end
    end

endmodule

// File: rtl/time_entry_loader.sv
// rtl/time_entry_loader.sv - keypad MM:SS entry, start validation and load/run control of the countdown chain
module time_entry_loader
    import microwave_pkg::*;
(
    input  logic                clk,
    input  logic                clrn,
    time_entry_loader_if.slave  bus
);

    state_t state, state_n;
    logic   start_prev;
    logic   clear_pend, clear_pend_n;
    logic   shift, clear, err_n;
    logic   start_evt, key_ok, buf_zero;

    assign start_evt = !bus.startn && start_prev;
    assign key_ok    = bus.key_valid && (bus.key <= BCD_MAX);
    assign buf_zero  = ({bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones} == '0);

    bcd_shift_reg u_buf (
        .clk      (clk),
        .clrn     (clrn),
        .shift    (shift),
        .clear    (clear),
        .din      (bus.key),
        .sec_ones (bus.sec_ones),
        .sec_tens (bus.sec_tens),
        .min_ones (bus.min_ones),
        .min_tens (bus.min_tens)
    );

    // Next state and buffer control in priority order: clear, zero, start, key.
    always_comb begin
        state_n      = state;
        shift        = 1'b0;
        clear        = 1'b0;
        err_n        = 1'b0;
        clear_pend_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_ok) begin
                    shift   = 1'b1;
                    state_n = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (!bus.clearn_key) begin
                    clear   = 1'b1;
                    state_n = ST_IDLE;
                end else if (start_evt && !buf_zero) begin
                    // A key arriving with a decided start (accepted or rejected) is dropped.
                    if (bus.sec_tens > SEC_TENS_MAX) err_n = 1'b1;
                    else                             state_n = ST_LOAD;
                end else if (key_ok) begin
                    shift = 1'b1;
                end
            end
            ST_LOAD: begin
                // A cancel seen during the load pulse is remembered and honoured in RUN.
                clear_pend_n = !bus.clearn_key;
                state_n      = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.clearn_key || clear_pend || bus.timer_zero) begin
                    clear   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, edge detector and registered control outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state      <= ST_IDLE;
            start_prev <= 1'b1;
            clear_pend <= 1'b0;
            bus.loadn  <= 1'b1;
            bus.en     <= 1'b0;
            bus.busy   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            state      <= state_n;
            start_prev <= bus.startn;
            clear_pend <= clear_pend_n;
            bus.loadn  <= (state_n != ST_LOAD);
            bus.en     <= (state_n == ST_RUN);
            bus.busy   <= (state_n == ST_LOAD) || (state_n == ST_RUN);
            bus.err    <= err_n;
        end
    end

endmodule

// File: tb/tb_time_entry_loader.sv
// tb/tb_time_entry_loader.sv - scoreboard bench for time_entry_loader
module tb_time_entry_loader;
    import microwave_pkg::*;

    logic clk = 1'b0;
    logic clrn;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [19:0] sb[$];
    logic [19:0] exp_v, got_v;

    time_entry_loader_if bus ();

    time_entry_loader dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ev(input logic l, input logic e, input logic b,
                                       input logic r, input logic [15:0] d);
        return {l, e, b, r, d};
    endfunction

    function automatic logic [19:0] obs();
        return {bus.loadn, bus.en, bus.busy, bus.err,
                bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        bus.key       = k;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        tick();
        clrn = 1'b1;
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL reset got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_load_run();
        logic [3:0]  keys [3] = '{4'd1, 4'd3, 4'd0};
        logic [15:0] bufs [3] = '{16'h0001, 16'h0013, 16'h0130};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ev(1, 0, 0, 0, bufs[i]));
            press(keys[i]);
            exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
            if (got_v !== exp_v) begin n_bad++; $display("FAIL entry_key%0d got=%h exp=%h", i, got_v, exp_v); end
        end
        bus.startn = 1'b0;
        sb.push_back(ev(0, 0, 1, 0, 16'h0130));
        sb.push_back(ev(1, 1, 1, 0, 16'h0130));
        sb.push_back(ev(1, 1, 1, 0, 16'h0130));
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
            if (got_v !== exp_v) begin n_bad++; $display("FAIL load_run_c%0d got=%h exp=%h", i, got_v, exp_v); end
        end
        bus.startn = 1'b1;
        bus.timer_zero = 1'b1;
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        tick();
        bus.timer_zero = 1'b0;
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL run_zero got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_reject();
        press(4'd7);
        press(4'd5);
        bus.startn = 1'b0;
        sb.push_back(ev(1, 0, 0, 1, 16'h0075));
        sb.push_back(ev(1, 0, 0, 0, 16'h0075));
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
            if (got_v !== exp_v) begin n_bad++; $display("FAIL reject_c%0d got=%h exp=%h", i, got_v, exp_v); end
        end
        bus.startn = 1'b1;
        tick();
        bus.clearn_key = 1'b0;
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        tick();
        bus.clearn_key = 1'b1;
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL reject_clear got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_key_filter();
        for (int i = 1; i <= 5; i++) press(4'(i));
        sb.push_back(ev(1, 0, 0, 0, 16'h2345));
        press(4'hA);
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL key_shift_bad got=%h exp=%h", got_v, exp_v); end
        bus.clearn_key = 1'b0;
        tick();
        bus.clearn_key = 1'b1;
        bus.startn = 1'b0;
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL start_idle got=%h exp=%h", got_v, exp_v); end
        bus.startn = 1'b1;
        tick();
        press(4'd0);
        bus.startn = 1'b0;
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL start_empty got=%h exp=%h", got_v, exp_v); end
        bus.startn = 1'b1;
        bus.clearn_key = 1'b0;
        tick();
        bus.clearn_key = 1'b1;
    endtask

    task automatic test_run_ignore();
        press(4'd2);
        bus.startn = 1'b0;
        tick();
        tick();
        bus.startn = 1'b1;
        sb.push_back(ev(1, 1, 1, 0, 16'h0002));
        press(4'd9);
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL run_key_ignored got=%h exp=%h", got_v, exp_v); end
        bus.timer_zero = 1'b1;
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        tick();
        bus.timer_zero = 1'b0;
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL run_ignore_zero got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_clear_priority();
        press(4'd4);
        bus.clearn_key = 1'b0;
        bus.startn = 1'b0;
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
            if (got_v !== exp_v) begin n_bad++; $display("FAIL clear_vs_start_c%0d got=%h exp=%h", i, got_v, exp_v); end
        end
        bus.clearn_key = 1'b1;
        bus.startn = 1'b1;
        tick();
    endtask

    task automatic test_deferred_clear();
        press(4'd6);
        bus.startn = 1'b0;
        sb.push_back(ev(0, 0, 1, 0, 16'h0006));
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL defer_load got=%h exp=%h", got_v, exp_v); end
        bus.clearn_key = 1'b0;
        sb.push_back(ev(1, 1, 1, 0, 16'h0006));
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL defer_run got=%h exp=%h", got_v, exp_v); end
        bus.clearn_key = 1'b1;
        bus.startn = 1'b1;
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL defer_clear got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_reset_in_load();
        press(4'd3);
        bus.startn = 1'b0;
        sb.push_back(ev(0, 0, 1, 0, 16'h0003));
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL rst_load_pre got=%h exp=%h", got_v, exp_v); end
        clrn = 1'b0;
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL rst_load got=%h exp=%h", got_v, exp_v); end
        clrn = 1'b1;
        sb.push_back(ev(1, 0, 0, 0, 16'h0000));
        tick();
        exp_v = sb.pop_front(); got_v = obs(); n_cmp++;
        if (got_v !== exp_v) begin n_bad++; $display("FAIL rst_load_after got=%h exp=%h", got_v, exp_v); end
        bus.startn = 1'b1;
        tick();
    endtask

    initial begin
        clrn           = 1'b1;
        bus.key        = '0;
        bus.key_valid  = 1'b0;
        bus.startn     = 1'b1;
        bus.clearn_key = 1'b1;
        bus.timer_zero = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_run();
        test_reject();
        test_key_filter();
        test_run_ignore();
        test_clear_priority();
        test_deferred_clear();
        test_reset_in_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
